wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer side of the ID-stage register file write port (regWrite/writeReg/writeData).
- Merges two result sources into one write per cycle:
  - the in-order pipeline's WB-stage result;
  - out-of-order results from long-latency units (load miss, divider).
- Long-latency results are buffered in a small FIFO.
- A 32-entry pending scoreboard lets ID stall on registers whose long-latency result has not yet been written.

Parameters:
- DEPTH, 4, long-latency FIFO entries (power of 2, ≥2).
- STARVE_MAX, 8, cycles a FIFO head may wait before forcing a pipeline stall.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- pipe_valid  in  1  WB-stage result present
- pipe_wen  in  1  WB-stage instruction writes rd
- pipe_rd  in  5  WB-stage destination
- pipe_data  in  32  WB-stage result
- pipe_stall  out  1  pipeline must hold pipe_* stable this cycle
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  FIFO can accept (not full)
- ll_rd  in  5  long-latency destination
- ll_data  in  32  long-latency result
- ll_issue  in  1  long-latency op issued this cycle
- ll_issue_rd  in  5  its destination
- query_rs1  in  5  ID source 1
- query_rs2  in  5  ID source 2
- query_rd  in  5  ID destination (WAW check)
- busy_rs1  out  1  query_rs1 pending
- busy_rs2  out  1  query_rs2 pending
- busy_rd  out  1  query_rd pending
- regWrite  out  1  register file write enable
- writeReg  out  5  register file write address
- writeData  out  32  register file write data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (resetn).
  - Reset clears: FIFO (empty), starve counter, scoreboard, regWrite, writeReg, writeData.
  - Reset also clears the combinational outputs' sources: pipe_stall=0, ll_ready=1.
  - Reset mid-operation discards buffered results and all pending bits.
- Handshakes:
  - Long-latency transfer occurs when ll_valid && ll_ready. ll_ready = !full, combinational from FIFO state only.
  - Pipeline write request: pipe_req = pipe_valid && pipe_wen && pipe_rd!=0.
  - Any request with rd==0 is accepted and discarded; it is never written and never touches the scoreboard.
- Selection, per cycle:
  - FIFO non-empty and (starve counter == STARVE_MAX or !pipe_req): pop head, write it. pipe_stall = pipe_req.
  - Otherwise, if pipe_req: write pipe result. pipe_stall = 0.
  - Otherwise: no write.
- Starve counter:
  - Increments while the FIFO is non-empty and the head is not popped.
  - Saturates at STARVE_MAX.
  - Clears on every pop or when the FIFO is empty.
- Output: regWrite/writeReg/writeData are registered.
  - The selected source in cycle N appears in cycle N+1.
  - regWrite=0 leaves writeReg/writeData holding their previous values.
- Latency:
  - Pipeline result: 1 cycle.
  - Long-latency result: pushed in cycle N, head in N+1, regWrite in N+2 at the earliest.
- FIFO boundaries:
  - Full: ll_ready=0, pushes ignored.
  - Simultaneous push and pop when full: not allowed; ll_ready stays 0.
  - Simultaneous push and pop when non-full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - pend[ll_issue_rd] is set on ll_issue with ll_issue_rd != 0.
  - pend[writeReg] is cleared on the edge where an output write originating from the FIFO (or bypass) is registered.
  - Set and clear of the same rd in the same cycle: set wins.
  - Pipeline-sourced writes never clear pend.
  - busy_* = pend[query_*], combinational; a query of x0 always returns 0.
  - Issuer rule: at most one outstanding long-latency op per rd, enforced via busy_rd.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if the FIFO is empty, !pipe_req and ll_valid, the ll input is selected directly and is not pushed.
  - regWrite appears in cycle N+1.
  - The scoreboard clears as for a FIFO write.
- Undefined: all long-latency results go through the FIFO (N+2 minimum latency).

Decomposition:
- Package wb_pkg:
  - REG_W=5, XLEN=32.
  - typedef wb_req_t {rd, data}.
  - enum wb_src_t {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYP}.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t.
  - Ports: push, pop, full, empty, head.
  - Parameter DEPTH.

Test Plan:
- Pipe only:
  - Stimulus: pipe_req rd=5 data=0x1234 at cycle 1.
  - Response: regWrite=1, writeReg=5, writeData=0x1234 at cycle 2. No writes for rd=0.
- Long-latency idle path:
  - Stimulus: ll_issue rd=7; later ll rd=7 data=0xDEAD, pipe idle.
  - Response: busy_rd(7)=1 until the write; write in N+2 (N+1 with WB_BYPASS_EN); busy clears the next cycle.
- Contention:
  - Stimulus: continuous pipe_req plus 1 FIFO entry.
  - Response: FIFO starves exactly STARVE_MAX cycles, then pipe_stall=1 for 1 cycle while the FIFO entry is written; the pipe value is written the next cycle.
- Full:
  - Stimulus: push DEPTH entries under continuous pipe_req with STARVE_MAX large.
  - Response: ll_ready=0 after the 4th push, no loss; entries drain in order.
- Same-cycle set and clear:
  - Stimulus: ll_issue rd=3 in the same cycle a FIFO write to rd=3 registers.
  - Response: pend[3] remains 1.
- Reset mid-operation:
  - Stimulus: assert resetn=0 with 3 FIFO entries and pending bits set.
  - Response: immediately regWrite=0, ll_ready=1, all busy=0; no writes after release until a new request.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file write arbiter.
package wb_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  // Source selected for the write issued in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_BYP
  } wb_src_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline / long-latency units / ID stage and the write arbiter.
// The slave modport is the arbiter's view; master is the surrounding core's view.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic             pipe_valid;
  logic             pipe_wen;
  logic [REG_W-1:0] pipe_rd;
  logic [XLEN-1:0]  pipe_data;
  logic             pipe_stall;

  logic             ll_valid;
  logic             ll_ready;
  logic [REG_W-1:0] ll_rd;
  logic [XLEN-1:0]  ll_data;
  logic             ll_issue;
  logic [REG_W-1:0] ll_issue_rd;

  logic [REG_W-1:0] query_rs1;
  logic [REG_W-1:0] query_rs2;
  logic [REG_W-1:0] query_rd;
  logic             busy_rs1;
  logic             busy_rs2;
  logic             busy_rd;

  logic             regWrite;
  logic [REG_W-1:0] writeReg;
  logic [XLEN-1:0]  writeData;

  modport master (
    output pipe_valid, pipe_wen, pipe_rd, pipe_data,
    output ll_valid, ll_rd, ll_data, ll_issue, ll_issue_rd,
    output query_rs1, query_rs2, query_rd,
    input  pipe_stall, ll_ready, busy_rs1, busy_rs2, busy_rd,
    input  regWrite, writeReg, writeData
  );

  modport slave (
    input  pipe_valid, pipe_wen, pipe_rd, pipe_data,
    input  ll_valid, ll_rd, ll_data, ll_issue, ll_issue_rd,
    input  query_rs1, query_rs2, query_rd,
    output pipe_stall, ll_ready, busy_rs1, busy_rs2, busy_rd,
    output regWrite, writeReg, writeData
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency write requests.
// Push while full and pop while empty are ignored; DEPTH must be a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: merges the in-order WB result with buffered
// long-latency results into one registered write per cycle, and tracks which
// registers still await a long-latency result.
// Optional macro WB_BYPASS_EN: an idle arbiter forwards a long-latency result
// straight to the write port instead of buffering it.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic         clk,
  input logic         resetn,
  wb_arbiter_if.slave bus
);

  localparam int unsigned StW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [StW-1:0] StarveLim = StW'(STARVE_MAX);
  localparam int unsigned NumRegs = 2 ** REG_W;

  logic             pipe_req;
  logic             byp_sel;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_req_t          fifo_head, ll_req;
  wb_src_t          sel_src;

  logic [StW-1:0]     starve_q, starve_d;
  logic [NumRegs-1:0] pend_q, pend_d;
  logic               reg_write_q, reg_write_d;
  logic [REG_W-1:0]   write_reg_q, write_reg_d;
  logic [XLEN-1:0]    write_data_q, write_data_d;

  assign pipe_req = bus.pipe_valid && bus.pipe_wen && (bus.pipe_rd != '0);
  assign ll_req   = '{rd: bus.ll_rd, data: bus.ll_data};

`ifdef WB_BYPASS_EN
  assign byp_sel = fifo_empty && !pipe_req && bus.ll_valid && (bus.ll_rd != '0);
`else
  assign byp_sel = 1'b0;
`endif

  // x0 results are accepted but never buffered.
  assign fifo_push = bus.ll_valid && !fifo_full && (bus.ll_rd != '0) && !byp_sel;
  assign fifo_pop  = (sel_src == SRC_FIFO);

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_data(ll_req),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign bus.ll_ready   = !fifo_full;
  assign bus.pipe_stall = pipe_req && fifo_pop;

  assign bus.busy_rs1 = (bus.query_rs1 != '0) && pend_q[bus.query_rs1];
  assign bus.busy_rs2 = (bus.query_rs2 != '0) && pend_q[bus.query_rs2];
  assign bus.busy_rd  = (bus.query_rd != '0) && pend_q[bus.query_rd];

  assign bus.regWrite  = reg_write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;

  // Pick this cycle's write source: the FIFO head wins when the pipe is idle
  // or the head has waited STARVE_MAX cycles.
  always_comb begin
    sel_src = SRC_NONE;
    if (!fifo_empty && ((starve_q == StarveLim) || !pipe_req)) sel_src = SRC_FIFO;
    else if (pipe_req)                                         sel_src = SRC_PIPE;
    else if (byp_sel)                                          sel_src = SRC_BYP;
  end

  // Next registered write; address/data hold when nothing is written.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    unique case (sel_src)
      SRC_FIFO: begin
        reg_write_d  = 1'b1;
        write_reg_d  = fifo_head.rd;
        write_data_d = fifo_head.data;
      end
      SRC_PIPE: begin
        reg_write_d  = 1'b1;
        write_reg_d  = bus.pipe_rd;
        write_data_d = bus.pipe_data;
      end
      SRC_BYP: begin
        reg_write_d  = 1'b1;
        write_reg_d  = bus.ll_rd;
        write_data_d = bus.ll_data;
      end
      default: ;
    endcase
  end

  // Starve counter: counts cycles the head is passed over, saturating.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)    starve_d = '0;
    else if (starve_q != StarveLim) starve_d = starve_q + 1'b1;
  end

  // Pending scoreboard: long-latency writes clear, issue sets; set is applied last so it wins.
  always_comb begin
    pend_d = pend_q;
    if ((sel_src == SRC_FIFO) || (sel_src == SRC_BYP)) pend_d[write_reg_d] = 1'b0;
    if (bus.ll_issue && (bus.ll_issue_rd != '0))      pend_d[bus.ll_issue_rd] = 1'b1;
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q     <= '0;
      pend_q       <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      starve_q     <= starve_d;
      pend_q       <= pend_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_req_t     mq[$];
  int          m_starve = 0;
  bit [31:0]   m_pend   = '0;
  bit          m_we     = 1'b0;
  logic [4:0]  m_reg    = '0;
  logic [31:0] m_data   = '0;
  bit          m_preq, m_room, m_take, m_byp;
  int          m_size0;
  wb_req_t     m_h;

  always @(posedge clk or negedge resetn) begin : model
    if (!resetn) begin
      mq.delete();
      m_starve = 0;
      m_pend   = '0;
      m_we     = 1'b0;
      m_reg    = '0;
      m_data   = '0;
    end else begin
      m_size0 = mq.size();
      m_preq  = bus.pipe_valid && bus.pipe_wen && (bus.pipe_rd != 5'd0);
      m_room  = m_size0 < DEPTH;
      m_take  = (m_size0 != 0) && ((m_starve == STARVE_MAX) || !m_preq);
      m_byp   = 1'b0;
`ifdef WB_BYPASS_EN
      m_byp = (m_size0 == 0) && !m_preq && bus.ll_valid && (bus.ll_rd != 5'd0);
`endif
      m_we = 1'b0;
      if (m_take) begin
        m_h = mq.pop_front();
        m_we = 1'b1; m_reg = m_h.rd; m_data = m_h.data;
        m_pend[m_h.rd] = 1'b0;
      end else if (m_preq) begin
        m_we = 1'b1; m_reg = bus.pipe_rd; m_data = bus.pipe_data;
      end else if (m_byp) begin
        m_we = 1'b1; m_reg = bus.ll_rd; m_data = bus.ll_data;
        m_pend[bus.ll_rd] = 1'b0;
      end
      if ((m_size0 == 0) || m_take)   m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
      if (bus.ll_valid && m_room && (bus.ll_rd != 5'd0) && !m_byp)
        mq.push_back('{rd: bus.ll_rd, data: bus.ll_data});
      if (bus.ll_issue && (bus.ll_issue_rd != 5'd0)) m_pend[bus.ll_issue_rd] = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit preq_now;
    if (resetn) begin
      preq_now = bus.pipe_valid && bus.pipe_wen && (bus.pipe_rd != 5'd0);
      chk("m_regWrite", bus.regWrite, m_we);
      chk("m_writeReg", bus.writeReg, m_reg);
      chk("m_writeData", bus.writeData, m_data);
      chk("m_ll_ready", bus.ll_ready, mq.size() < DEPTH);
      chk("m_pipe_stall", bus.pipe_stall,
          preq_now && (mq.size() != 0) && (m_starve == STARVE_MAX));
      chk("m_busy_rs1", bus.busy_rs1, (bus.query_rs1 != 0) && m_pend[bus.query_rs1]);
      chk("m_busy_rs2", bus.busy_rs2, (bus.query_rs2 != 0) && m_pend[bus.query_rs2]);
      chk("m_busy_rd", bus.busy_rd, (bus.query_rd != 0) && m_pend[bus.query_rd]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    bus.pipe_valid  = 1'b0; bus.pipe_wen  = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
    bus.ll_valid    = 1'b0; bus.ll_rd     = '0;   bus.ll_data = '0;
    bus.ll_issue    = 1'b0; bus.ll_issue_rd = '0;
    bus.query_rs1   = '0;   bus.query_rs2 = '0;   bus.query_rd = '0;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic [4:0] rd, input logic [31:0] data);
    bus.pipe_valid = 1'b1; bus.pipe_wen = 1'b1; bus.pipe_rd = rd; bus.pipe_data = data;
  endtask

  initial begin : stim
    wb_req_t obs[$];
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_regWrite", bus.regWrite, 0);
    chk("rst_writeReg", bus.writeReg, 0);
    chk("rst_writeData", bus.writeData, 0);
    chk("rst_ll_ready", bus.ll_ready, 1);
    chk("rst_pipe_stall", bus.pipe_stall, 0);
    step_cycle();

    // Pipe only: 1-cycle latency; x0 never written and address holds
    set_pipe(5'd5, 32'h1234);
    step_cycle();
    idle_inputs();
    @(negedge clk);
    chk("pipe_regWrite", bus.regWrite, 1);
    chk("pipe_writeReg", bus.writeReg, 5);
    chk("pipe_writeData", bus.writeData, 32'h1234);
    step_cycle();
    set_pipe(5'd0, 32'hFFFF);
    step_cycle();
    idle_inputs();
    @(negedge clk);
    chk("x0_regWrite", bus.regWrite, 0);
    chk("x0_writeReg_hold", bus.writeReg, 5);
    step_cycle();

    // Long-latency idle path
    bus.ll_issue = 1'b1; bus.ll_issue_rd = 5'd7; bus.query_rd = 5'd7;
    step_cycle();
    bus.ll_issue = 1'b0;
    @(negedge clk);
    chk("ll_busy_set", bus.busy_rd, 1);
    step_cycle();
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_data = 32'hDEAD;
    step_cycle();
    bus.ll_valid = 1'b0;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("ll_n1_regWrite", bus.regWrite, 1);
    chk("ll_n1_writeReg", bus.writeReg, 7);
    chk("ll_n1_writeData", bus.writeData, 32'hDEAD);
    chk("ll_n1_busy", bus.busy_rd, 0);
`else
    chk("ll_n1_regWrite", bus.regWrite, 0);
    chk("ll_n1_busy", bus.busy_rd, 1);
    step_cycle();
    @(negedge clk);
    chk("ll_n2_regWrite", bus.regWrite, 1);
    chk("ll_n2_writeReg", bus.writeReg, 7);
    chk("ll_n2_writeData", bus.writeData, 32'hDEAD);
    chk("ll_n2_busy", bus.busy_rd, 0);
`endif
    step_cycle();
    idle_inputs();

    // Contention: head waits STARVE_MAX cycles, then one stall cycle
    set_pipe(5'd9, 32'h9999);
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd10; bus.ll_data = 32'hA0A0;
    @(negedge clk);
    chk("cont_stall_push", bus.pipe_stall, 0);
    step_cycle();
    bus.ll_valid = 1'b0;
    for (int k = 1; k <= STARVE_MAX + 1; k++) begin
      @(negedge clk);
      chk($sformatf("cont_stall_k%0d", k), bus.pipe_stall, (k == STARVE_MAX + 1) ? 1 : 0);
      step_cycle();
    end
    @(negedge clk);
    chk("cont_fifo_writeReg", bus.writeReg, 10);
    chk("cont_fifo_writeData", bus.writeData, 32'hA0A0);
    step_cycle();
    @(negedge clk);
    chk("cont_pipe_regWrite", bus.regWrite, 1);
    chk("cont_pipe_writeReg", bus.writeReg, 9);
    chk("cont_pipe_writeData", bus.writeData, 32'h9999);
    step_cycle();

    // Full: four pushes under continuous pipe traffic, fifth ignored, in-order drain
    set_pipe(5'd1, 32'h1111);
    for (int i = 0; i < DEPTH; i++) begin
      bus.ll_valid = 1'b1; bus.ll_rd = 5'(11 + i); bus.ll_data = 32'hB000 + i;
      @(negedge clk);
      chk($sformatf("full_ready_%0d", i), bus.ll_ready, 1);
      step_cycle();
    end
    bus.ll_rd = 5'd15; bus.ll_data = 32'h0BAD;
    @(negedge clk);
    chk("full_ready_0", bus.ll_ready, 0);
    step_cycle();
    bus.ll_valid = 1'b0;
    for (int c = 0; c < 60 && obs.size() < DEPTH; c++) begin
      @(negedge clk);
      if (bus.regWrite && (bus.writeReg != 5'd1))
        obs.push_back('{rd: bus.writeReg, data: bus.writeData});
      step_cycle();
    end
    chk("full_drain_count", obs.size(), DEPTH);
    for (int i = 0; i < obs.size(); i++) begin
      chk($sformatf("full_order_rd%0d", i), obs[i].rd, 11 + i);
      chk($sformatf("full_order_data%0d", i), obs[i].data, 32'hB000 + i);
    end
    idle_inputs();
    step_cycle();

    // Same-cycle set and clear of rd=3: set wins
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd3; bus.ll_data = 32'h3333;
`ifdef WB_BYPASS_EN
    bus.ll_issue = 1'b1; bus.ll_issue_rd = 5'd3;
    step_cycle();
    bus.ll_valid = 1'b0; bus.ll_issue = 1'b0;
`else
    step_cycle();
    bus.ll_valid = 1'b0;
    bus.ll_issue = 1'b1; bus.ll_issue_rd = 5'd3;
    step_cycle();
    bus.ll_issue = 1'b0;
`endif
    bus.query_rd = 5'd3;
    @(negedge clk);
    chk("same_regWrite", bus.regWrite, 1);
    chk("same_writeReg", bus.writeReg, 3);
    chk("same_busy3", bus.busy_rd, 1);
    step_cycle();
    idle_inputs();

    // Reset mid-operation with three buffered entries and pending bits
    set_pipe(5'd2, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      bus.ll_valid = 1'b1; bus.ll_rd = 5'(20 + i); bus.ll_data = 32'hC0 + i;
      bus.ll_issue = 1'b1; bus.ll_issue_rd = 5'(20 + i);
      step_cycle();
    end
    bus.ll_valid = 1'b0; bus.ll_issue = 1'b0;
    bus.query_rs1 = 5'd20; bus.query_rs2 = 5'd21; bus.query_rd = 5'd22;
    @(negedge clk);
    chk("pre_rst_busy_rs1", bus.busy_rs1, 1);
    chk("pre_rst_busy_rd", bus.busy_rd, 1);
    #2;
    resetn = 1'b0;
    idle_inputs();
    bus.query_rs1 = 5'd20; bus.query_rs2 = 5'd21; bus.query_rd = 5'd22;
    #1;
    chk("mid_rst_regWrite", bus.regWrite, 0);
    chk("mid_rst_ll_ready", bus.ll_ready, 1);
    chk("mid_rst_pipe_stall", bus.pipe_stall, 0);
    chk("mid_rst_busy_rs1", bus.busy_rs1, 0);
    chk("mid_rst_busy_rs2", bus.busy_rs2, 0);
    chk("mid_rst_busy_rd", bus.busy_rd, 0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_nowrite_%0d", c), bus.regWrite, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
